// File: rtl/aibnd_avmm_rst_seq_if.sv
// Channel-side bundle of the AVMM reset / clock-gate sequencer: soft reset
// requests in, per-channel gated clocks, resets, enables and sequence status out.
interface aibnd_avmm_rst_seq_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] soft_rst_req;
  logic [NUM_CH-1:0] pcs_clk;
  logic [NUM_CH-1:0] pcs_clkb;
  logic [NUM_CH-1:0] ch_rstb;
  logic [NUM_CH-1:0] ch_clk_en;
  logic              seq_busy;
  logic              seq_done;

  modport master (
    output soft_rst_req,
    input  pcs_clk, pcs_clkb, ch_rstb, ch_clk_en, seq_busy, seq_done
  );

  modport slave (
    input  soft_rst_req,
    output pcs_clk, pcs_clkb, ch_rstb, ch_clk_en, seq_busy, seq_done
  );
endinterface

// File: rtl/aibnd_avmm_rst_seq.sv
// Filters the AVMM block reset, then releases NUM_CH channels STAGGER cycles apart,
// ungating each clock CLK_LEAD cycles before its reset deasserts (and the reverse on drain).
//
// top state | meaning
// S_HOLD    | block reset asserted, everything off
// S_FILT    | counting consecutive high samples of avmm_rstb
// S_REL     | slot counter running, channels released on their slots
// S_WAIT    | every slot passed, waiting for all channels to reach ON
// S_RUN     | sequence complete, channels follow their soft reset requests
// ch state  | meaning
// CH_OFF    | clock gated, reset asserted
// CH_UNGATE | clock running, reset held for CLK_LEAD cycles
// CH_ON     | clock running, reset released
// CH_DRAIN  | reset asserted, clock kept for CLK_LEAD cycles
module aibnd_avmm_rst_seq #(
  parameter int NUM_CH     = 4,
  parameter int SYNC_DEPTH = 2,
  parameter int STAGGER    = 4,
  parameter int CLK_LEAD   = 2
) (
  input  logic                avmm_clk,
  input  logic                avmm_rstb,
  aibnd_avmm_rst_seq_if.slave bus
);
  localparam int LAST_SLOT = (NUM_CH - 1) * STAGGER;
  localparam int TW        = $clog2(LAST_SLOT + 2);
  localparam int FW        = $clog2(SYNC_DEPTH + 1);
  localparam int CW        = $clog2(CLK_LEAD + 1);

  typedef enum logic [2:0] {S_HOLD, S_FILT, S_REL, S_WAIT, S_RUN} top_state_t;
  typedef enum logic [1:0] {CH_OFF, CH_UNGATE, CH_ON, CH_DRAIN} ch_state_t;

  top_state_t        top_q, top_d;
  logic [FW-1:0]     filt_q, filt_d;
  logic [TW-1:0]     slot_q, slot_d;
  ch_state_t         ch_q [NUM_CH];
  ch_state_t         ch_d [NUM_CH];
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d, rstb_q, rstb_d, gate_q, rel, pcs_clk_w;
  logic              done_q, all_on;

  always_ff @(posedge avmm_clk) begin
    if (!avmm_rstb) begin
      top_q  <= S_HOLD;
      filt_q <= '0;
      slot_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i]  <= CH_OFF;
        cnt_q[i] <= '0;
      end
      en_q   <= '0;
      rstb_q <= '0;
      done_q <= 1'b0;
    end else begin
      top_q  <= top_d;
      filt_q <= filt_d;
      slot_q <= slot_d;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i]  <= ch_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      en_q   <= en_d;
      rstb_q <= rstb_d;
      done_q <= all_on;
    end
  end

  always_comb begin
    top_d  = top_q;
    filt_d = filt_q;
    slot_d = slot_q;
    all_on = 1'b1;
    rel    = '0;
    en_d   = '0;
    rstb_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_d[i]  = ch_q[i];
      cnt_d[i] = cnt_q[i];
      if (ch_q[i] != CH_ON) all_on = 1'b0;
      // A channel stays releasable once its slot has passed, so a late drop of its request still ungates it.
      rel[i] = ((top_q == S_REL) && (int'(slot_q) >= i * STAGGER)) ||
               (top_q == S_WAIT) || (top_q == S_RUN);
    end

    case (top_q)
      S_HOLD: begin
        if (SYNC_DEPTH == 1) begin
          top_d  = S_REL;
          slot_d = '0;
        end else begin
          top_d  = S_FILT;
          filt_d = FW'(1);
        end
      end
      S_FILT: begin
        if (filt_q == FW'(SYNC_DEPTH - 1)) begin
          top_d  = S_REL;
          slot_d = '0;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end
      S_REL: begin
        if (slot_q == TW'(LAST_SLOT)) top_d = S_WAIT;
        else                          slot_d = slot_q + 1'b1;
      end
      S_WAIT: if (all_on) top_d = S_RUN;
      default: ;
    endcase

    for (int i = 0; i < NUM_CH; i++) begin
      case (ch_q[i])
        CH_OFF: begin
          if (rel[i] && !bus.soft_rst_req[i]) begin
            ch_d[i]  = CH_UNGATE;
            cnt_d[i] = CW'(CLK_LEAD - 1);
          end
        end
        CH_UNGATE: begin
          if (bus.soft_rst_req[i]) begin
            ch_d[i]  = CH_DRAIN;
            cnt_d[i] = CW'(CLK_LEAD - 1);
          end else if (cnt_q[i] == '0) begin
            ch_d[i] = CH_ON;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        CH_ON: begin
          if (bus.soft_rst_req[i]) begin
            ch_d[i]  = CH_DRAIN;
            cnt_d[i] = CW'(CLK_LEAD - 1);
          end
        end
        CH_DRAIN: begin
          if (cnt_q[i] == '0) ch_d[i] = CH_OFF;
          else                cnt_d[i] = cnt_q[i] - 1'b1;
        end
        default: ch_d[i] = CH_OFF;
      endcase
      en_d[i]   = (ch_d[i] != CH_OFF);
      rstb_d[i] = (ch_d[i] == CH_ON);
    end
  end

  // Enable captured on the low phase so the AND gate never chops a high phase.
  always_ff @(negedge avmm_clk) begin
    if (!avmm_rstb) gate_q <= '0;
    else            gate_q <= en_q;
  end

  assign pcs_clk_w     = gate_q & {NUM_CH{avmm_clk}};
  assign bus.pcs_clk   = pcs_clk_w;
  assign bus.pcs_clkb  = ~pcs_clk_w;
  assign bus.ch_clk_en = en_q;
  assign bus.ch_rstb   = rstb_q;
  assign bus.seq_done  = done_q;
  assign bus.seq_busy  = (top_q == S_FILT) || (top_q == S_REL) || (top_q == S_WAIT);
endmodule
